// File: rtl/icache_pkg.sv
// Shared types and address slicing for the direct-mapped instruction cache.
package icache_pkg;

    localparam int INDEX_BITS = 6;
    localparam int TAG_BITS   = 30 - INDEX_BITS;
    localparam int LINES      = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    function automatic logic [INDEX_BITS-1:0] idx_of(input logic [31:0] pc);
        return pc[INDEX_BITS+1:2];
    endfunction

    function automatic logic [TAG_BITS-1:0] tag_of(input logic [31:0] pc);
        return pc[31:INDEX_BITS+2];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read port, synchronous write port.
module icache_array
    import icache_pkg::*;
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] widx,
    input  logic [TAG_BITS-1:0]   wtag,
    input  logic [31:0]           wdata,
    input  logic [INDEX_BITS-1:0] ridx,
    output logic                  rvalid,
    output logic [TAG_BITS-1:0]   rtag,
    output logic [31:0]           rdata
);

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tags [LINES];
    logic [31:0]         data [LINES];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid <= '0;
        end else if (we) begin
            valid[widx] <= 1'b1;
        end
    end

    // Tag and data need no reset; the valid bit guards them.
    always_ff @(posedge clk_in) begin
        if (we) begin
            tags[widx] <= wtag;
            data[widx] <= wdata;
        end
    end

    assign rvalid = valid[ridx];
    assign rtag   = tags[ridx];
    assign rdata  = data[ridx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped one-word-line icache controller between IFU and memctrl.
module icache_ctrl
    import icache_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_received,
    input  logic        mem_done,
    input  logic [31:0] mem_data,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    state_t              state;
    logic                drop;
    logic                rvalid;
    logic [TAG_BITS-1:0] rtag;
    logic [31:0]         rdata;
    logic                accept;
    logic                hit;
    logic                fill;

    assign fetch_ready = (state == IDLE) && !flush;
    assign accept      = rdy_in && fetch_valid && fetch_ready;
    assign hit         = rvalid && (rtag == tag_of(fetch_pc));
    // mem_addr holds the miss address for the whole transaction.
    assign fill        = rdy_in && (state == WAIT) && mem_done;

    icache_array u_array (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .we     (fill),
        .widx   (idx_of(mem_addr)),
        .wtag   (tag_of(mem_addr)),
        .wdata  (mem_data),
        .ridx   (idx_of(fetch_pc)),
        .rvalid (rvalid),
        .rtag   (rtag),
        .rdata  (rdata)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            drop       <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rdy_in) begin
            unique case (state)
                IDLE: begin
                    inst_valid <= 1'b0;
                    if (accept && hit) begin
                        inst_valid <= 1'b1;
                        inst       <= rdata;
                        inst_pc    <= fetch_pc;
                        if (hit_count != '1) hit_count <= hit_count + 1'b1;
                    end else if (accept) begin
                        mem_req  <= 1'b1;
                        mem_addr <= {fetch_pc[31:2], 2'b00};
                        state    <= REQ;
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
                    end
                end
                REQ: begin
                    if (flush) drop <= 1'b1;
                    if (mem_received) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_done) begin
                        state <= IDLE;
                        drop  <= 1'b0;
                        // A flush landing on the fill cycle also kills the reply.
                        if (!drop && !flush) begin
                            inst_valid <= 1'b1;
                            inst       <= mem_data;
                            inst_pc    <= mem_addr;
                        end
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped, one-word-per-line instruction cache controller between the instruction fetch unit and the memory controller's icache request port.
- Serves hits from a local tag/data array with one-cycle latency, one fetch per cycle.
- On a miss, sequences a single 4-byte fetch through the memory controller's req/received/done handshake, fills the line and returns the word.
- Handles ROB flushes mid-miss without breaking the memory controller handshake.

Parameters:
- INDEX_BITS, 6, line count = 2^INDEX_BITS; index = pc[INDEX_BITS+1:2].
- TAG_BITS, 30-INDEX_BITS, tag = pc[31:INDEX_BITS+2].

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- rst_in  input  1  reset. Asynchronous, active-high; clears all state immediately.
- rdy_in  input  1  global ready; when 0, all state and outputs hold.
- fetch_valid  input  1  IFU requests the instruction at fetch_pc.
- fetch_pc  input  32  fetch address; bits [1:0] ignored.
- fetch_ready  output  1  1 iff state IDLE and no flush this cycle; a fetch is accepted when fetch_valid & fetch_ready.
- inst_valid  output  1  one-cycle pulse; inst/inst_pc valid.
- inst  output  32  instruction word.
- inst_pc  output  32  address of inst.
- flush  input  1  ROB misprediction/clear; cancels any pending response.
- mem_req  output  1  to memctrl icache_in; held until mem_received.
- mem_addr  output  32  to memctrl icache_address_in; word-aligned miss address.
- mem_received  input  1  memctrl icache_received pulse: request latched.
- mem_done  input  1  memctrl icache_task_out pulse: mem_data valid this cycle.
- mem_data  input  32  memctrl value_load.
- hit_count  output  32  saturating count of accepted hits.
- miss_count  output  32  saturating count of accepted misses.

Behaviour:
- Reset:
  - State IDLE, all valid bits 0, drop 0.
  - Outputs: mem_req 0, mem_addr 0, inst_valid 0, inst 0, inst_pc 0, both counters 0.
  - Reset mid-miss abandons the transaction; memctrl shares rst_in.
- IDLE:
  - Accepted fetch with valid[idx] & tag match (hit): inst_valid=1, inst=data[idx], inst_pc=fetch_pc in the next cycle. State stays IDLE; back-to-back hits are one per cycle. hit_count+1.
  - Accepted miss: latch miss_pc = {fetch_pc[31:2],2'b00}; mem_req<=1, mem_addr<=miss_pc; state REQ; miss_count+1.
  - No accepted fetch: inst_valid<=0.
- REQ:
  - mem_req stays 1 with mem_addr stable.
  - On mem_received=1: mem_req<=0 next cycle; state WAIT.
- WAIT:
  - On mem_done=1: data[idx(miss_pc)]<=mem_data, tag written, valid<=1 → state IDLE.
  - If drop=0: inst_valid=1, inst=mem_data, inst_pc=miss_pc next cycle.
  - If drop=1: no response; drop<=0.
- Miss latency: at least 3 cycles plus memctrl service time; fetch_ready=0 throughout REQ/WAIT.
- flush:
  - In IDLE: the fetch in the same cycle is not accepted, and inst_valid=0 next cycle (flush beats hit).
  - In REQ/WAIT: drop<=1. The handshake still completes and the fill is still written (the data is correct), but no inst_valid is produced.
  - The cache array is never invalidated by flush.
- mem_received and mem_done arriving in the same cycle is illegal; memctrl guarantees at least one cycle between them.
- A mem_done while in IDLE or REQ is ignored.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- rdy_in=0: no transitions; inst_valid, mem_req and all other outputs hold their values.

Decomposition:
- Shared package icache_pkg:
  - State encoding IDLE=2'd0, REQ=2'd1, WAIT=2'd2.
  - Derived widths: INDEX_BITS, TAG_BITS, index and tag slice helpers.
- Sub-module icache_array:
  - valid/tag/data storage; one combinational read port (index → valid, tag, data); one synchronous write port.
  - Valid bits are cleared by rst_in; tag and data are not reset.

Test Plan:
- Cold miss: reset; fetch_pc=0x00000010; memctrl model asserts received 1 cycle after req and done 4 cycles later with data 0x00A00093 → mem_addr=0x10, inst_valid pulse with inst=0x00A00093 and inst_pc=0x10; miss_count=1.
- Hit pipeline: after the cold-miss fill, fetch 0x10 on 3 consecutive cycles → inst_valid high 3 consecutive cycles, inst=0x00A00093 each; hit_count=3; mem_req stays 0.
- Conflict: fill 0x10, then fetch 0x110 (same index for INDEX_BITS=6, different tag) → miss; mem_addr=0x110; line replaced; a following fetch of 0x10 misses again.
- Flush mid-miss: miss on 0x20, flush asserted while in WAIT → no inst_valid; fill still written; a later fetch of 0x20 hits with inst_valid one cycle after acceptance.
- Flush vs hit: flush and fetch_valid to a cached pc in the same cycle → inst_valid=0 next cycle; hit_count unchanged.
- rdy_in stall and reset: rdy_in=0 for 5 cycles during REQ → mem_req and mem_addr held, state unchanged. rst_in pulsed mid-WAIT → mem_req=0, fetch_ready=1, all lines invalid (next fetch misses).
